// File: rtl/rtl_top_pkg.sv
// Shared constants and types for the flip-flop based storage array.
package rtl_top_pkg;

  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned MemDepth     = 1 << DefAddrWidth;

  typedef logic [DefDataWidth-1:0] word_t;

endpackage

// File: rtl/rtl_top_word.sv
// One storage word: a register with asynchronous active-low clear and a load enable.
module rtl_top_word #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/rtl_top_mem.sv
// Single-port storage array held in flip-flops, with a registered read-before-write port.
module rtl_top_mem
  import rtl_top_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH    = DefDataWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic [DATA_WIDTH-1:0]    qout
);

  localparam int unsigned NumWords = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NumWords];
  logic [NumWords-1:0]   load;
  logic [DATA_WIDTH-1:0] qout_q;

  for (genvar i = 0; i < NumWords; i++) begin : g_word
    assign load[i] = clken && (addr == ADDRESS_WIDTH'(i));

    rtl_top_word #(
      .Width (DATA_WIDTH)
    ) u_word (
      .clk  (clk),
      .rst  (rst),
      .load (load[i]),
      .d    (data),
      .q    (mem[i])
    );
  end

  // mem[addr] is sampled at the same edge that overwrites it, so qout sees the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qout_q <= '0;
    end else if (clken) begin
      qout_q <= mem[addr];
    end
  end

  assign qout = qout_q;

endmodule

// File: tb/tb_rtl_top_mem.sv
// Directed self-checking bench for rtl_top_mem with default 4-bit address, 8-bit data.
module tb_rtl_top_mem;
  import rtl_top_pkg::*;

  logic       clk;
  logic       rst;
  logic       clken;
  logic [3:0] addr;
  word_t      data;
  word_t      qout;

  int unsigned checks;
  int unsigned failures;

  rtl_top_mem #(
    .ADDRESS_WIDTH (4),
    .DATA_WIDTH    (8)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .addr  (addr),
    .data  (data),
    .qout  (qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One enabled cycle; returns after the edge with qout settled.
  task automatic access(input logic [3:0] a, input word_t d);
    @(negedge clk);
    addr  = a;
    data  = d;
    clken = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clken    = 1'b0;
    addr     = '0;
    data     = '0;

    // Reset: clears qout without a clock
    #1 rst = 1'b0;
    #1 check_eq("reset_qout", qout, 8'h00);
    #48 rst = 1'b1;

    for (int a = 0; a < 16; a++) begin
      access(4'(a), 8'h00);
      check_eq($sformatf("reset_sweep[%0d]", a), qout, 8'h00);
    end

    // Lossless fill
    for (int a = 0; a < 16; a++) access(4'(a), 8'(a) ^ 8'hA5);
    for (int a = 0; a < 16; a++) begin
      access(4'(a), 8'h00);
      check_eq($sformatf("fill[%0d]", a), qout, 8'(a) ^ 8'hA5);
    end

    // Read-before-write on address 3 (holds 0x00)
    access(4'd3, 8'h11);
    check_eq("rbw_first", qout, 8'h00);
    access(4'd3, 8'h22);
    check_eq("rbw_second", qout, 8'h11);

    // Clock enable hold: load qout with 0x22, then 5 disabled cycles with toggling inputs
    access(4'd3, 8'h22);
    check_eq("ce_setup", qout, 8'h22);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clken = 1'b0;
      addr  = 4'(c * 3 + 1);
      data  = 8'(8'h3C ^ (c * 37));
      @(posedge clk);
      #1 check_eq($sformatf("ce_hold[%0d]", c), qout, 8'h22);
    end
    // Readback: all zero except address 3 = 0x22
    for (int a = 0; a < 16; a++) begin
      access(4'(a), (a == 3) ? 8'h22 : 8'h00);
      check_eq($sformatf("ce_readback[%0d]", a), qout, (a == 3) ? 8'h22 : 8'h00);
    end

    // Reset mid-operation
    for (int a = 0; a < 16; a++) access(4'(a), 8'hFF);
    access(4'd0, 8'hFF);
    check_eq("pre_reset_ff", qout, 8'hFF);
    #2;
    clken = 1'b0;
    rst   = 1'b0;
    #1 check_eq("mid_reset_qout", qout, 8'h00);
    #2 rst = 1'b1;
    for (int a = 0; a < 16; a++) begin
      access(4'(a), 8'h00);
      check_eq($sformatf("post_reset[%0d]", a), qout, 8'h00);
    end

    // Wrap-around: 15 and 0 hold independent values
    access(4'd15, 8'h5A);
    check_eq("wrap_w15", qout, 8'h00);
    access(4'd0, 8'hC3);
    check_eq("wrap_w0", qout, 8'h00);
    access(4'd15, 8'h5A);
    check_eq("wrap_r15", qout, 8'h5A);
    access(4'd0, 8'hC3);
    check_eq("wrap_r0", qout, 8'hC3);

    @(negedge clk);
    clken = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
